// File: rtl/video_stream_sink.sv
// Consumer end of the 24-bit pixel ready/valid stream: tracks raster position,
// accumulates per-frame checksum, counts colour mismatches and can throttle ready.
module video_stream_sink #(
  parameter int          H_ACTIVE     = 800,
  parameter int          V_ACTIVE     = 600,
  parameter logic [19:0] MISMATCH_MAX = 20'hFFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Enable,
  input  logic [3:0]  StallEvery,
  input  logic [23:0] ExpColor,
  input  logic        VideoValid,
  input  logic [23:0] Video,
  output logic        VideoReady,
  output logic [9:0]  PixelX,
  output logic [9:0]  PixelY,
  output logic        FrameDone,
  output logic [15:0] FrameCount,
  output logic [23:0] FrameChecksum,
  output logic [19:0] MismatchCount
);

  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        done_q, done_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic [23:0] fsum_q, fsum_d, acc_q, acc_d;
  logic [19:0] mis_q, mis_d;
  logic        xfer;

  assign xfer = VideoValid & ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = 4'd0;
    x_d     = x_q;
    y_d     = y_q;
    done_d  = 1'b0;
    fcnt_d  = fcnt_q;
    fsum_d  = fsum_q;
    acc_d   = acc_q;
    mis_d   = mis_q;

    case (state_q)
      IDLE:  if (Enable) state_d = RUN;
      RUN: begin
        // >= rather than == so a lowered StallEvery cannot be skipped past
        if (!Enable)
          state_d = IDLE;
        else if (StallEvery != 4'd0 && ({1'b0, cnt_q} + 5'd1) >= {1'b0, StallEvery})
          state_d = STALL;
        else
          cnt_d = cnt_q + 4'd1;
      end
      STALL: state_d = Enable ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == RUN);

    if (xfer) begin
      if (Video != ExpColor && mis_q != MISMATCH_MAX) mis_d = mis_q + 20'd1;
      acc_d = acc_q + Video;
      if (x_q == X_LAST) begin
        x_d = 10'd0;
        if (y_q == Y_LAST) begin
          y_d    = 10'd0;
          done_d = 1'b1;
          fcnt_d = fcnt_q + 16'd1;
          fsum_d = acc_q + Video;
          acc_d  = 24'd0;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      cnt_q   <= 4'd0;
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      done_q  <= 1'b0;
      fcnt_q  <= 16'd0;
      fsum_q  <= 24'd0;
      acc_q   <= 24'd0;
      mis_q   <= 20'd0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
      fsum_q  <= fsum_d;
      acc_q   <= acc_d;
      mis_q   <= mis_d;
    end
  end

  assign VideoReady    = ready_q;
  assign PixelX        = x_q;
  assign PixelY        = y_q;
  assign FrameDone     = done_q;
  assign FrameCount    = fcnt_q;
  assign FrameChecksum = fsum_q;
  assign MismatchCount = mis_q;

endmodule

// File: doc/video_stream_sink.md
# video_stream_sink

Consumer end of the 24-bit pixel ready/valid stream produced by the DVI pattern generator. Asserts VideoReady, accepts one pixel per handshake, tracks raster position over an H_ACTIVE x V_ACTIVE frame, and reports per-frame results:
- pixel checksum
- mismatch count against an expected colour
- frame count

It can also throttle VideoReady to exercise upstream backpressure. It sits between the pattern generator and the frame-buffer/feature-detection datapath, or stands alone as an on-chip stream checker.

## Interface
- H_ACTIVE, 800, pixels per line
- V_ACTIVE, 600, lines per frame
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-low; sampled on clock rising edge
- Enable  in  1  1 = accept pixels; 0 = hold VideoReady low, position frozen
- StallEvery  in  4  throttle: 0 = ready every enabled cycle; k>0 = one stall cycle after every k ready cycles
- ExpColor  in  24  expected pixel value for mismatch check
- VideoValid  in  1  upstream pixel valid
- Video  in  24  upstream pixel {R[23:16],G[15:8],B[7:0]}
- VideoReady  out  1  registered ready to upstream
- PixelX  out  10  column of next pixel to be accepted
- PixelY  out  10  line of next pixel to be accepted
- FrameDone  out  1  one-cycle pulse after last pixel of a frame
- FrameCount  out  16  completed frames, wraps at 65535->0
- FrameChecksum  out  24  sum mod 2^24 of all pixels of last completed frame
- MismatchCount  out  20  pixels != ExpColor since reset, saturates at 0xFFFFF

## Operation
- Transfer occurs on a rising edge where VideoValid=1 and VideoReady=1; no other cycle changes position, checksum or mismatch state.
- States:
  - IDLE: VideoReady=0.
  - RUN: VideoReady=1.
  - STALL: VideoReady=0 for exactly one cycle.
- Transitions (all registered):
  - IDLE->RUN when Enable=1.
  - RUN->IDLE when Enable=0.
  - RUN->STALL when StallEvery!=0 and the ready-cycle counter reaches StallEvery.
  - STALL->RUN if Enable=1, else IDLE.
- Ready-cycle counter (4 bit):
  - Counts cycles spent in RUN, whether or not a transfer occurs.
  - Clears on entry to STALL or IDLE.
  - A change to StallEvery takes effect at the next comparison.
- Position on each transfer:
  - PixelX increments.
  - At PixelX=H_ACTIVE-1: PixelX->0 and PixelY increments.
  - At (H_ACTIVE-1, V_ACTIVE-1): both ->0 (frame wrap).
- Checksum:
  - Running 24-bit accumulator adds Video on every transfer (mod 2^24).
  - On the frame-wrap transfer, FrameChecksum <= accumulator + Video and the accumulator <= 0.
- Mismatch: on every transfer, if Video!=ExpColor, MismatchCount increments unless already 0xFFFFF.
- FrameDone and FrameCount:
  - The frame-wrap transfer sets FrameDone=1 for the next cycle only.
  - It also increments FrameCount, wrapping modulo 2^16.
- Enable=0 mid-frame: the position, accumulator and counts are retained. The frame resumes when Enable returns; the partial frame is not discarded.
- Reset (reset=0) at any time, including mid-frame:
  - State -> IDLE.
  - All outputs and internal counters -> 0 on that edge.

## Timing
- Reset values: VideoReady=0, PixelX=0, PixelY=0, FrameDone=0, FrameCount=0, FrameChecksum=0, MismatchCount=0.
- VideoReady is a flop output. First assertion is one cycle after the first edge sampling reset=1 and Enable=1.
- Enable deassertion drops VideoReady on the following edge. A pixel offered in the same cycle as the Enable=0 sample is still accepted if VideoReady=1.
- Output latencies, measured from the transfer edge:
  - PixelX/PixelY, MismatchCount and accumulator: updated on the same edge, visible next cycle.
  - FrameDone, FrameCount and FrameChecksum: visible in the cycle after the frame-wrap transfer.
- Throughput:
  - 1 pixel/cycle with StallEvery=0.
  - k pixels per k+1 cycles with StallEvery=k (continuous valid).
- VideoValid=1 while VideoReady=0 has no effect; Video may change freely.

## Test plan
- Reset, then Enable=1, StallEvery=0, H_ACTIVE=4, V_ACTIVE=2, continuous VideoValid, Video=0x000001:
  - VideoReady rises 1 cycle after the Enable sample.
  - FrameDone pulses after the 8th transfer.
  - FrameChecksum=0x000008, FrameCount=1.
- StallEvery=3, continuous valid: VideoReady repeats 1,1,1,0; 6 transfers take exactly 8 cycles.
- ExpColor=0xFF0000; stream 8 pixels with 3 equal to 0x00FF00: MismatchCount=3. Preload near saturation: the count holds at 0xFFFFF.
- Enable=0 after 5 of 8 pixels, idle 10 cycles, re-enable:
  - PixelX=1, PixelY=1 are held while disabled.
  - FrameDone occurs after 3 more transfers.
- Video=0xFFFFFF for a whole frame of 8 pixels: FrameChecksum=0xFFFFF8 (mod 2^24 wrap).
- Assert reset=0 mid-frame, with PixelX=2 and MismatchCount=4: the next cycle shows all outputs 0 and VideoReady=0.
